// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves branch-class instructions one cycle after acceptance.
// A taken branch pulses redirect_o with redirect_pc_o=target_i, then holds flush_o (and
// drops ready_o) for FLUSH_CYCLES cycles. A not-taken branch reports pc_i+1 and stays
// ready, so not-taken branches can be accepted every cycle.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   valid_i / ready_o       accept handshake (accept = valid_i & ready_o)
//   br_type_i               0 NONE, 1 BEQ, 2 BNE, 3 BGT, 4 BLT, 5 JMP, 6-7 reserved
//   gt_i, lt_i, eq_i        comparator flags (team encoding: gt_i means A<B, lt_i means A>B)
//   pc_i, target_i          instruction PC and branch target
//   redirect_o              one-cycle pulse, fetch loads redirect_pc_o
//   redirect_pc_o           next PC of the last accepted branch (held otherwise)
//   flush_o                 squash younger stages
//   flag_err_o              sticky: non-one-hot flags seen on an accepted conditional branch
//   branch_cnt_o            saturating count of accepted branches (type != NONE)
//   taken_cnt_o             saturating count of accepted taken branches
module branch_resolve_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       br_type_i,
  input  logic             gt_i,
  input  logic             lt_i,
  input  logic             eq_i,
  input  logic [15:0]      pc_i,
  input  logic [15:0]      target_i,
  output logic             redirect_o,
  output logic [15:0]      redirect_pc_o,
  output logic             flush_o,
  output logic             flag_err_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  localparam logic [2:0] BrNone = 3'd0;
  localparam logic [2:0] BrBeq  = 3'd1;
  localparam logic [2:0] BrBne  = 3'd2;
  localparam logic [2:0] BrBgt  = 3'd3;
  localparam logic [2:0] BrBlt  = 3'd4;
  localparam logic [2:0] BrJmp  = 3'd5;

  localparam logic [2:0]       FlushLast = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne    = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e           state_q;
  logic [2:0]       fcnt_q;
  logic             redirect_q;
  logic [15:0]      redirect_pc_q;
  logic             flush_q;
  logic             flag_err_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] taken_cnt_q;

  logic accept;
  logic is_cond;
  logic flags_ok;
  logic raw_taken;
  logic taken;
  logic flag_bad;

  always_comb begin
    raw_taken = 1'b0;
    is_cond   = 1'b0;
    case (br_type_i)
      BrBeq:   begin raw_taken = eq_i;  is_cond = 1'b1; end
      BrBne:   begin raw_taken = ~eq_i; is_cond = 1'b1; end
      BrBgt:   begin raw_taken = gt_i;  is_cond = 1'b1; end
      BrBlt:   begin raw_taken = lt_i;  is_cond = 1'b1; end
      BrJmp:   raw_taken = 1'b1;
      default: raw_taken = 1'b0;
    endcase
    // Exactly one flag set: odd parity, but not all three.
    flags_ok = (gt_i ^ lt_i ^ eq_i) & ~(gt_i & lt_i & eq_i);
    flag_bad = is_cond & ~flags_ok;
    taken    = raw_taken & ~flag_bad;
  end

  assign ready_o = (state_q == StIdle);
  assign accept  = valid_i & ready_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      fcnt_q        <= 3'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 16'h0000;
      flush_q       <= 1'b0;
      flag_err_q    <= 1'b0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
    end else begin
      redirect_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            redirect_pc_q <= taken ? target_i : pc_i + 16'd1;
            if (flag_bad) flag_err_q <= 1'b1;
            if ((br_type_i != BrNone) && (branch_cnt_q != '1)) begin
              branch_cnt_q <= branch_cnt_q + CntOne;
            end
            if (taken) begin
              if (taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + CntOne;
              redirect_q <= 1'b1;
              flush_q    <= 1'b1;
              fcnt_q     <= FlushLast;
              state_q    <= StFlush;
            end
          end
        end
        StFlush: begin
          // fcnt_q counts the flush cycles still to go after the current one.
          if (fcnt_q == 3'd0) begin
            flush_q <= 1'b0;
            state_q <= StIdle;
          end else begin
            fcnt_q <= fcnt_q - 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign flush_o       = flush_q;
  assign flag_err_o    = flag_err_q;
  assign branch_cnt_o  = branch_cnt_q;
  assign taken_cnt_o   = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: a vector table applied in a loop with expected outputs
// queued at drive time, plus hand sequences for flush, reset and counter saturation.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_i = 1'b0;
  logic [2:0]  br_type_i = 3'd0;
  logic        gt_i = 1'b0, lt_i = 1'b0, eq_i = 1'b0;
  logic [15:0] pc_i = 16'h0, target_i = 16'h0;

  logic        ready_o, redirect_o, flush_o, flag_err_o;
  logic [15:0] redirect_pc_o, branch_cnt_o, taken_cnt_o;
  logic        ready4, redirect4, flush4, err4;
  logic [15:0] rpc4;
  logic [3:0]  bc4, tc4;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o), .br_type_i(br_type_i),
    .gt_i(gt_i), .lt_i(lt_i), .eq_i(eq_i), .pc_i(pc_i), .target_i(target_i),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
    .flag_err_o(flag_err_o), .branch_cnt_o(branch_cnt_o), .taken_cnt_o(taken_cnt_o)
  );

  branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready4), .br_type_i(br_type_i),
    .gt_i(gt_i), .lt_i(lt_i), .eq_i(eq_i), .pc_i(pc_i), .target_i(target_i),
    .redirect_o(redirect4), .redirect_pc_o(rpc4), .flush_o(flush4),
    .flag_err_o(err4), .branch_cnt_o(bc4), .taken_cnt_o(tc4)
  );

  typedef struct {
    logic [2:0]  ty;
    logic        gt, lt, eq;
    logic [15:0] pc, tgt;
    logic        taken;
    logic [15:0] npc;
    logic        err;
  } vec_t;

  typedef struct {
    logic        redirect;
    logic [15:0] npc;
    logic        err;
    logic [15:0] bc, tc;
  } exp_t;

  exp_t        sbq[$];
  vec_t        tbl[16];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_bc = 16'h0, exp_tc = 16'h0;
  logic        exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one branch, update the model and queue the expected registered outcome.
  task automatic drive(input vec_t v);
    exp_t e;
    br_type_i = v.ty; gt_i = v.gt; lt_i = v.lt; eq_i = v.eq;
    pc_i = v.pc; target_i = v.tgt; valid_i = 1'b1;
    if (v.ty != 3'd0 && exp_bc != 16'hFFFF) exp_bc++;
    if (v.taken && exp_tc != 16'hFFFF) exp_tc++;
    exp_err = exp_err | v.err;
    e = '{v.taken, v.npc, exp_err, exp_bc, exp_tc};
    sbq.push_back(e);
  endtask

  task automatic compare_out(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      check({name, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      check({name, ".redirect"}, 32'(redirect_o), 32'(e.redirect));
      check({name, ".redirect_pc"}, 32'(redirect_pc_o), 32'(e.npc));
      check({name, ".flag_err"}, 32'(flag_err_o), 32'(e.err));
      check({name, ".branch_cnt"}, 32'(branch_cnt_o), 32'(e.bc));
      check({name, ".taken_cnt"}, 32'(taken_cnt_o), 32'(e.tc));
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    drive(v);
    tick();
    valid_i = 1'b0;
    compare_out(name);
    if (v.taken) begin
      check({name, ".flush1"}, 32'(flush_o), 32'd1);
      check({name, ".ready1"}, 32'(ready_o), 32'd0);
      tick();
      check({name, ".redir2"}, 32'(redirect_o), 32'd0);
      check({name, ".flush2"}, 32'(flush_o), 32'd1);
      check({name, ".ready2"}, 32'(ready_o), 32'd0);
      check({name, ".pc_hold"}, 32'(redirect_pc_o), 32'(v.npc));
      tick();
      check({name, ".flush3"}, 32'(flush_o), 32'd0);
      check({name, ".ready3"}, 32'(ready_o), 32'd1);
    end else begin
      check({name, ".flush"}, 32'(flush_o), 32'd0);
      check({name, ".ready"}, 32'(ready_o), 32'd1);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, ".redirect"}, 32'(redirect_o), 32'd0);
    check({name, ".flush"}, 32'(flush_o), 32'd0);
    check({name, ".flag_err"}, 32'(flag_err_o), 32'd0);
    check({name, ".redirect_pc"}, 32'(redirect_pc_o), 32'd0);
    check({name, ".branch_cnt"}, 32'(branch_cnt_o), 32'd0);
    check({name, ".taken_cnt"}, 32'(taken_cnt_o), 32'd0);
    check({name, ".ready"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    //          ty    gt lt eq  pc        tgt       tk  npc       err
    tbl[0]  = '{3'd3, 0, 1, 0, 16'hFFFF, 16'h1234, 0, 16'h0000, 0};  // BGT not taken, wrap
    tbl[1]  = '{3'd1, 0, 0, 1, 16'h0010, 16'h0040, 1, 16'h0040, 0};  // BEQ taken
    tbl[2]  = '{3'd2, 1, 0, 0, 16'h0020, 16'h0080, 1, 16'h0080, 0};  // BNE taken
    tbl[3]  = '{3'd2, 0, 0, 1, 16'h0030, 16'h0090, 0, 16'h0031, 0};  // BNE not taken
    tbl[4]  = '{3'd3, 1, 0, 0, 16'h0100, 16'h0200, 1, 16'h0200, 0};  // BGT taken
    tbl[5]  = '{3'd4, 0, 1, 0, 16'h0300, 16'h0050, 1, 16'h0050, 0};  // BLT taken
    tbl[6]  = '{3'd4, 1, 0, 0, 16'h0400, 16'h0500, 0, 16'h0401, 0};  // BLT not taken
    tbl[7]  = '{3'd0, 0, 0, 1, 16'h1234, 16'h4321, 0, 16'h1235, 0};  // NONE, not counted
    tbl[8]  = '{3'd5, 1, 1, 1, 16'h2000, 16'h0ABC, 1, 16'h0ABC, 0};  // JMP ignores flags
    tbl[9]  = '{3'd6, 0, 0, 1, 16'h3000, 16'h3333, 0, 16'h3001, 0};  // reserved
    tbl[10] = '{3'd7, 1, 1, 0, 16'h7FFE, 16'h0000, 0, 16'h7FFF, 0};  // reserved, bad flags ok
    tbl[11] = '{3'd4, 1, 1, 0, 16'h4000, 16'h4444, 0, 16'h4001, 1};  // BLT gt=lt=1 -> error
    tbl[12] = '{3'd1, 0, 0, 0, 16'h5000, 16'h5555, 0, 16'h5001, 1};  // BEQ no flags
    tbl[13] = '{3'd1, 0, 0, 1, 16'h6000, 16'h6666, 1, 16'h6666, 0};  // error stays sticky
    tbl[14] = '{3'd2, 0, 0, 0, 16'h7000, 16'h7777, 0, 16'h7001, 1};  // BNE, no flags: forced NT
    tbl[15] = '{3'd2, 1, 0, 1, 16'h8000, 16'h8888, 0, 16'h8001, 1};  // BNE two flags

    // Reset state
    tick();
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_reset.ready", 32'(ready_o), 32'd1);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back not-taken acceptances, valid_i held high throughout
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v = '{3'd1, 1'b1, 1'b0, 1'b0, 16'h0A00 + 16'(i), 16'hBEEF, 1'b0, 16'h0A01 + 16'(i), 1'b0};
      @(negedge clk);
      drive(v);
      tick();
      compare_out($sformatf("b2b%0d", i));
      check($sformatf("b2b%0d.ready", i), 32'(ready_o), 32'd1);
    end
    valid_i = 1'b0;

    // JMP, then valid held with a taken BEQ during FLUSH: only one redirect
    begin
      vec_t v;
      int   pulses;
      v = '{3'd5, 1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0100, 1'b1, 16'h0100, 1'b0};
      @(negedge clk);
      drive(v);
      tick();
      compare_out("jmpflush");
      br_type_i = 3'd1; eq_i = 1'b1; pc_i = 16'h0300; target_i = 16'h0200;
      pulses = 0;
      for (int c = 0; c < 2; c++) begin
        tick();
        if (redirect_o) pulses++;
      end
      valid_i = 1'b0;
      check("jmpflush.pulses", 32'(pulses), 32'd0);
      check("jmpflush.ready", 32'(ready_o), 32'd1);
      check("jmpflush.bc", 32'(branch_cnt_o), 32'(exp_bc));
      check("jmpflush.tc", 32'(taken_cnt_o), 32'(exp_tc));
      tick();
      check("jmpflush.idle_redir", 32'(redirect_o), 32'd0);
      check("jmpflush.pc_hold", 32'(redirect_pc_o), 32'h0100);
      check("jmpflush.bc_hold", 32'(branch_cnt_o), 32'(exp_bc));
    end

    // Reset in the second FLUSH cycle, with a simultaneous valid JMP
    begin
      vec_t v;
      v = '{3'd5, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0AAA, 1'b1, 16'h0AAA, 1'b0};
      @(negedge clk);
      drive(v);
      tick();
      compare_out("rstflush");
      tick();
      check("rstflush.flush_c2", 32'(flush_o), 32'd1);
      reset = 1'b1; valid_i = 1'b1; br_type_i = 3'd5; target_i = 16'h0BBB;
      tick();
      check_reset_vals("rstflush");
      reset = 1'b0; valid_i = 1'b0;
      exp_bc = 16'h0; exp_tc = 16'h0; exp_err = 1'b0;
      tick();
      check("rstflush.ready_after", 32'(ready_o), 32'd1);
      check("rstflush.flush_after", 32'(flush_o), 32'd0);
    end

    // Counter saturation on the CNT_W=4 instance
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v = '{3'd5, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0C00 + 16'(i), 1'b1, 16'h0C00 + 16'(i), 1'b0};
      run_vec(v, $sformatf("sat%0d", i));
      if (i == 14) check("sat.tc4_at15", 32'(tc4), 32'hF);
    end
    check("sat.tc4", 32'(tc4), 32'hF);
    check("sat.bc4", 32'(bc4), 32'hF);
    check("sat.rpc4", 32'(rpc4), 32'h0C0F);
    check("sat.state4", 32'({ready4, flush4, redirect4, err4}), 32'b1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
